// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the hazard controller and its interface.
// Contents: the register address width, the architectural zero register
// and the encoding of the hazard FSM states.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // Register 0 is hard-wired to zero, so writes to it never create a dependency.
    localparam reg_addr_t REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOAD_STALL   = 2'd1,
        BRANCH_FLUSH = 2'd2
    } hazard_state_t;

endpackage : cpu_pkg

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   master : pipeline side. It drives the decode operands and the execute-stage
//            control fields, and receives flush/stall plus the status counters.
//   slave  : hazard controller side.
// CNT_W must match the CNT_W of the controller instance bound to this bundle.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic             dec_valid;
    reg_addr_t        dec_src1;
    reg_addr_t        dec_src2;
    reg_addr_t        ex_alu_dest;
    logic             ex_reg_write_enable;
    logic             ex_mem_rd;
    logic             ex_load_pc;
    logic             flush;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] stall_events;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output dec_valid, dec_src1, dec_src2,
        output ex_alu_dest, ex_reg_write_enable, ex_mem_rd, ex_load_pc,
        input  flush, stall, busy, stall_events, flush_events
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2,
        input  ex_alu_dest, ex_reg_write_enable, ex_mem_rd, ex_load_pc,
        output flush, stall, busy, stall_events, flush_events
    );

endinterface : pipeline_hazard_ctrl_if

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance event counts.
//   clk   : clock
//   rst   : asynchronous active-high reset, clears count
//   inc   : add one on the next rising edge, unless already all-ones
//   count : current value; it holds at all-ones and never wraps
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the decode->execute control register.
// It generates flush/stall from the decode operands and the execute-stage
// control fields:
//   - load-use hazards stall fetch/decode for MEM_LATENCY cycles;
//   - PC redirects squash the wrong path for FLUSH_CYCLES cycles.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : pipeline_hazard_ctrl_if.slave. Inputs are the dec_* and ex_*
//              fields; outputs are flush, stall, busy and the stall_events /
//              flush_events saturating counters.
module pipeline_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,   // 1..15, includes the detection cycle
    parameter int MEM_LATENCY  = 1,   // 1..15, includes the detection cycle
    parameter int CNT_W        = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_ctrl_if.slave        bus
);

    hazard_state_t state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          flush_c, stall_c;
    logic          stall_inc, flush_inc;
    logic          load_use, redirect;

    assign redirect = bus.ex_load_pc;

    assign load_use = bus.dec_valid && bus.ex_mem_rd && bus.ex_reg_write_enable
                   && (bus.ex_alu_dest != REG_ZERO)
                   && ((bus.dec_src1 == bus.ex_alu_dest) || (bus.dec_src2 == bus.ex_alu_dest));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_c   = 1'b0;
        stall_c   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;

        unique case (state_q)
            IDLE, LOAD_STALL: begin
                if (redirect) begin
                    // A redirect aborts a pending stall: the stalled decode
                    // instruction is on the wrong path anyway.
                    flush_c   = 1'b1;
                    flush_inc = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = BRANCH_FLUSH;
                        cnt_d   = 4'(FLUSH_CYCLES - 1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end else if (state_q == LOAD_STALL) begin
                    flush_c = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                    end
                end else if (load_use) begin
                    flush_c   = 1'b1;
                    stall_c   = 1'b1;
                    stall_inc = 1'b1;
                    if (MEM_LATENCY > 1) begin
                        state_d = LOAD_STALL;
                        cnt_d   = 4'(MEM_LATENCY - 1);
                    end
                end
            end
            BRANCH_FLUSH: begin
                // The execute stage holds a bubble here, so its fields are ignored.
                flush_c = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The control register has no reset of its own, so reset holds it cleared
    // through flush and suppresses stall.
    assign bus.flush = rst ? 1'b1 : flush_c;
    assign bus.stall = rst ? 1'b0 : stall_c;
    assign bus.busy  = (state_q != IDLE);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (bus.stall_events)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (bus.flush_events)
    );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with FLUSH_CYCLES=2, MEM_LATENCY=3,
// CNT_W=4. Inputs change 1 ns after the rising edge; outputs are compared 1 ns
// later, well clear of the next edge.
module tb_pipeline_hazard_ctrl;
    import cpu_pkg::*;

    localparam int FC = 2;
    localparam int ML = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_vec  = 0;
    int n_miss = 0;
    int exp_se = 0;
    int exp_fe = 0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (FC),
        .MEM_LATENCY  (ML),
        .CNT_W        (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] dst, input logic we, input logic mrd,
                         input logic lpc);
        bus.dec_valid           = v;
        bus.dec_src1            = s1;
        bus.dec_src2            = s2;
        bus.ex_alu_dest         = dst;
        bus.ex_reg_write_enable = we;
        bus.ex_mem_rd           = mrd;
        bus.ex_load_pc          = lpc;
        #1;
    endtask

    task automatic quiet();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Load hazard: load into r5, decode reads r5 on source 2.
    task automatic hazard(input logic lpc);
        drive(1'b1, 5'd7, 5'd5, 5'd5, 1'b1, 1'b1, lpc);
    endtask

    task automatic test_reset();
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if ({bus.flush, bus.stall, bus.busy} !== 3'b100) begin
                $display("FAIL reset_ctl c%0d: flush/stall/busy got %b want 100", i,
                         {bus.flush, bus.stall, bus.busy});
                n_miss++;
            end
            n_vec++;
            if (bus.stall_events !== 4'd0 || bus.flush_events !== 4'd0) begin
                $display("FAIL reset_cnt c%0d: got se=%0d fe=%0d want 0/0", i,
                         bus.stall_events, bus.flush_events);
                n_miss++;
            end
        end
        tick();
        rst = 1'b0;
        quiet();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({bus.flush, bus.stall, bus.busy} !== 3'b000) begin
                $display("FAIL post_reset c%0d: flush/stall/busy got %b want 000", i,
                         {bus.flush, bus.stall, bus.busy});
                n_miss++;
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        hazard(1'b0);
        for (int i = 0; i < ML + 1; i++) begin
            logic [2:0] want;
            want = (i == 0) ? 3'b110 : (i < ML) ? 3'b111 : 3'b000;
            n_vec++;
            if ({bus.flush, bus.stall, bus.busy} !== want) begin
                $display("FAIL load_use c%0d: flush/stall/busy got %b want %b", i,
                         {bus.flush, bus.stall, bus.busy}, want);
                n_miss++;
            end
            tick();
            quiet();
        end
        exp_se++;
        n_vec++;
        if (bus.stall_events !== 4'(exp_se)) begin
            $display("FAIL load_use_cnt: stall_events got %0d want %0d", bus.stall_events, exp_se);
            n_miss++;
        end
    endtask

    task automatic test_no_hazard();
        // Destination r0, sources r0: must not stall.
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL zero_reg: stall got %b want 0", bus.stall);
            n_miss++;
        end
        tick();
        // Matching register but no write enable.
        drive(1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL no_write: stall got %b want 0", bus.stall);
            n_miss++;
        end
        tick();
        // Hazard pattern on an empty decode slot.
        drive(1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (bus.stall !== 1'b0) begin
            $display("FAIL dec_invalid: stall got %b want 0", bus.stall);
            n_miss++;
        end
        tick();
        quiet();
        n_vec++;
        if (bus.stall_events !== 4'(exp_se) || bus.busy !== 1'b0) begin
            $display("FAIL no_hazard_cnt: se=%0d busy=%b want se=%0d busy=0",
                     bus.stall_events, bus.busy, exp_se);
            n_miss++;
        end
    endtask

    task automatic test_branch();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < FC + 1; i++) begin
            logic want;
            want = (i < FC);
            n_vec++;
            if (bus.flush !== want || bus.stall !== 1'b0) begin
                $display("FAIL branch c%0d: flush/stall got %b%b want %b0", i,
                         bus.flush, bus.stall, want);
                n_miss++;
            end
            tick();
            // A second redirect while flushing must be ignored.
            if (i == 0) drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
            else        quiet();
        end
        exp_fe++;
        n_vec++;
        if (bus.flush_events !== 4'(exp_fe) || bus.busy !== 1'b0) begin
            $display("FAIL branch_cnt: fe=%0d busy=%b want fe=%0d busy=0",
                     bus.flush_events, bus.busy, exp_fe);
            n_miss++;
        end
    endtask

    task automatic test_simultaneous();
        // Redirect and load-use in IDLE together: redirect wins.
        hazard(1'b1);
        for (int i = 0; i < FC + 1; i++) begin
            logic [1:0] want;
            want = (i < FC) ? 2'b10 : 2'b00;
            n_vec++;
            if ({bus.flush, bus.stall} !== want) begin
                $display("FAIL simul_idle c%0d: flush/stall got %b want %b", i,
                         {bus.flush, bus.stall}, want);
                n_miss++;
            end
            tick();
            quiet();
        end
        exp_fe++;
        n_vec++;
        if (bus.flush_events !== 4'(exp_fe) || bus.stall_events !== 4'(exp_se)) begin
            $display("FAIL simul_idle_cnt: fe=%0d se=%0d want fe=%0d se=%0d",
                     bus.flush_events, bus.stall_events, exp_fe, exp_se);
            n_miss++;
        end
        // Load-use, then a redirect in the second stall cycle.
        hazard(1'b0);
        n_vec++;
        if ({bus.flush, bus.stall} !== 2'b11) begin
            $display("FAIL simul_ls_det: flush/stall got %b want 11", {bus.flush, bus.stall});
            n_miss++;
        end
        tick();
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        exp_se++;
        for (int i = 0; i < FC + 1; i++) begin
            logic [1:0] want;
            want = (i < FC) ? 2'b10 : 2'b00;
            n_vec++;
            if ({bus.flush, bus.stall} !== want) begin
                $display("FAIL simul_ls c%0d: flush/stall got %b want %b", i,
                         {bus.flush, bus.stall}, want);
                n_miss++;
            end
            tick();
            quiet();
        end
        exp_fe++;
        n_vec++;
        if (bus.flush_events !== 4'(exp_fe) || bus.stall_events !== 4'(exp_se)
            || bus.busy !== 1'b0) begin
            $display("FAIL simul_ls_cnt: fe=%0d se=%0d busy=%b want fe=%0d se=%0d busy=0",
                     bus.flush_events, bus.stall_events, bus.busy, exp_fe, exp_se);
            n_miss++;
        end
    endtask

    task automatic test_back_to_back();
        // Hazard re-detected the very cycle the first stall ends: 2*ML stall cycles.
        for (int i = 0; i < 2 * ML + 1; i++) begin
            logic want;
            want = (i < 2 * ML);
            if (i == 0 || i == ML) hazard(1'b0);
            else                   quiet();
            n_vec++;
            if (bus.stall !== want) begin
                $display("FAIL b2b c%0d: stall got %b want %b", i, bus.stall, want);
                n_miss++;
            end
            tick();
        end
        exp_se += 2;
        quiet();
        n_vec++;
        if (bus.stall_events !== 4'(exp_se)) begin
            $display("FAIL b2b_cnt: stall_events got %0d want %0d", bus.stall_events, exp_se);
            n_miss++;
        end
    endtask

    task automatic test_reset_mid();
        hazard(1'b0);
        tick();
        quiet();
        rst = 1'b1;
        #1;
        n_vec++;
        if ({bus.flush, bus.stall, bus.busy} !== 3'b100 || bus.stall_events !== 4'd0) begin
            $display("FAIL reset_mid: flush/stall/busy=%b se=%0d want 100 se=0",
                     {bus.flush, bus.stall, bus.busy}, bus.stall_events);
            n_miss++;
        end
        tick();
        rst = 1'b0;
        exp_se = 0;
        exp_fe = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_vec++;
            if ({bus.flush, bus.stall, bus.busy} !== 3'b000) begin
                $display("FAIL after_reset_mid c%0d: flush/stall/busy got %b want 000", i,
                         {bus.flush, bus.stall, bus.busy});
                n_miss++;
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
            tick();
            quiet();
            if (exp_fe < 15) exp_fe++;
            n_vec++;
            if (bus.flush_events !== 4'(exp_fe)) begin
                $display("FAIL sat r%0d: flush_events got %0d want %0d", i, bus.flush_events, exp_fe);
                n_miss++;
            end
            tick();
        end
        tick();
        n_vec++;
        if (bus.flush_events !== 4'd15 || bus.flush !== 1'b0) begin
            $display("FAIL sat_hold: fe=%0d flush=%b want fe=15 flush=0",
                     bus.flush_events, bus.flush);
            n_miss++;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_pipeline_hazard_ctrl
